weight_fetch: RTL and testbench
===============================

# weight_fetch

Upstream sequencer for `weight_feed`. On a start pulse it reads one 4×32-bit weight tile from the weight SRAM. Each word holds one row's four bytes. It presents the four words on `wA..wD`, pulses `en_in` to load `weight_feed`, then drives `en_out` for four non-stalled cycles so the tile streams MSB-byte-first into the systolic array. It reports `busy` and `done` to the tile scheduler.

## Interface
- `ADDR_W`, default 8: weight SRAM word-address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a tile fetch; sampled only in IDLE.
- `base_addr` in ADDR_W: word address of the row-A word; rows B/C/D are at +1/+2/+3. Captured with `start`.
- `stall` in 1: array not ready; holds streaming. Ignored outside STREAM.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when the tile has fully streamed.
- `mem_rd_en` out 1: SRAM read strobe.
- `mem_addr` out ADDR_W: SRAM read address.
- `mem_rdata` in 32: SRAM read data, valid exactly one cycle after `mem_rd_en`.
- `wA`, `wB`, `wC`, `wD` out 32 each: tile row words, to `weight_feed` `dinA..dinD`.
- `en_in` out 1: load strobe to `weight_feed`.
- `en_out` out 1: shift strobe to `weight_feed`.

## Operation
- States, each transition taken on a clock edge:
  - IDLE → READ when `start` is high.
  - READ → WAIT after 4 cycles.
  - WAIT → LOAD after 1 cycle.
  - LOAD → STREAM after 1 cycle.
  - STREAM → DONE after 4 non-stalled cycles.
  - DONE → IDLE after 1 cycle.
- READ:
  - `mem_rd_en` = 1 for 4 cycles.
  - `mem_addr` = base+0, +1, +2, +3 in that order, computed modulo 2^ADDR_W (wrap-around is legal).
  - A 2-bit counter selects the row.
- Capture: `mem_rdata` is registered into `wA`, `wB`, `wC`, `wD` on the cycle after each read. A one-cycle delayed copy of `mem_rd_en` plus the row index qualifies capture. `mem_rdata` is never sampled otherwise.
- LOAD:
  - `en_in` = 1 for exactly one cycle.
  - `wA..wD` are all valid and stable in this cycle.
- STREAM:
  - `en_out` = !`stall`.
  - A 2-bit beat counter advances only on non-stalled cycles.
  - `en_in` and `en_out` are never high in the same cycle.
- DONE: `done` = 1 for one cycle; `busy` is still 1.
- `start` while `busy` is ignored: no latch, no queue. A new `start` is accepted in the cycle after DONE.
- `wA..wD` hold their last values until overwritten by the next tile's capture.
- `rst` mid-operation:
  - Next state is IDLE, all outputs return to reset values, counters clear.
  - No `done` is issued for the aborted tile.
- Reset values: `busy`, `done`, `mem_rd_en`, `en_in`, `en_out` = 0; `mem_addr` = 0; `wA..wD` = 0.

## Timing
- Control outputs (`mem_rd_en`, `mem_addr`, `en_in`, `done`, `busy`) are registered or decoded from registered state only. The exception is `en_out`, which is combinational in `stall` during STREAM.
- Cycle numbering below has `start` sampled at cycle 0 with no stalls:
  - cycles 1–4: `mem_rd_en` = 1, addresses base..base+3.
  - cycles 2–5: data returns; `wD` is valid from cycle 6.
  - cycle 6: `en_in` = 1.
  - cycles 7–10: `en_out` = 1.
  - cycle 11: `done` = 1.
  - cycle 12: IDLE.
- Start-to-done latency is 11 + N cycles, where N is the number of stalled STREAM cycles.
- Downstream bytes appear on `weight_feed` `dout*` one cycle after each `en_out` cycle (its output register). That latency is outside this block.

## Structure
- Shared package `weight_pkg` holds:
  - the state enum (IDLE, READ, WAIT, LOAD, STREAM, DONE);
  - WORD_W = 32, NUM_ROWS = 4, BYTES_PER_WORD = 4.
  - `weight_feed` integration uses the same constants.
- No sub-module: a single FSM plus two 2-bit counters and four 32-bit capture registers.
- Instantiated beside `weight_feed` in the array top.

## Test plan
1. Basic fetch:
   - Stimulus: mem[0x10..0x13] = 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00; `start` with base 0x10 at cycle 0.
   - Response: reads at 0x10..0x13 in cycles 1–4; `en_in` in cycle 6 with `wA`=0x11223344, `wB`=0x55667788, `wC`=0x99AABBCC, `wD`=0xDDEEFF00; `en_out` in cycles 7–10; `done` in cycle 11.
2. Stall:
   - Stimulus: same as test 1, plus `stall` = 1 in cycles 8–9.
   - Response: `en_out` is low in cycles 8–9 and high in cycles 7, 10, 11, 12; `done` in cycle 13.
3. Address wrap:
   - Stimulus: `ADDR_W` = 8, base 0xFE.
   - Response: `mem_addr` sequence is 0xFE, 0xFF, 0x00, 0x01; words land in `wA..wD` in that order.
4. Start while busy:
   - Stimulus: a second `start` with base 0x40 at cycle 3.
   - Response: no reads at 0x40, exactly one `done` (cycle 11).
5. Reset mid-stream:
   - Stimulus: `rst` high in cycle 8.
   - Response: from cycle 9, all outputs are at reset values and no `done` follows. A `start` after reset runs the full 11-cycle sequence.
6. Back-to-back:
   - Stimulus: `start` in cycle 12 (first IDLE cycle after `done`).
   - Response: it is accepted; reads in cycles 13–16; `done` in cycle 23.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared constants and FSM states for the weight tile fetch path.
// weight_feed integration uses the same word/row geometry.
package weight_pkg;

    localparam int WORD_W         = 32;
    localparam int NUM_ROWS       = 4;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        LOAD,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/weight_fetch.sv
// Reads one 4-row weight tile from SRAM, loads weight_feed, then
// streams it out for four non-stalled cycles.
module weight_fetch
    import weight_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] wA,
    output logic [WORD_W-1:0] wB,
    output logic [WORD_W-1:0] wC,
    output logic [WORD_W-1:0] wD,
    output logic              en_in,
    output logic              en_out
);

    state_t            state;
    logic [1:0]        row;
    logic [1:0]        beat;
    logic [1:0]        cap_row;
    logic              cap_en;
    logic [ADDR_W-1:0] base;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_rd_en = (state == READ);
    assign en_in     = (state == LOAD);
    assign en_out    = (state == STREAM) && !stall;
    assign mem_addr  = (state == READ) ? base + ADDR_W'(row) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            beat    <= '0;
            cap_row <= '0;
            cap_en  <= 1'b0;
            base    <= '0;
            wA      <= '0;
            wB      <= '0;
            wC      <= '0;
            wD      <= '0;
        end else begin
            // Read data lags the strobe by one cycle; the delayed row picks the slot.
            cap_en  <= (state == READ);
            cap_row <= row;
            if (cap_en) begin
                unique case (cap_row)
                    2'd0: wA <= mem_rdata;
                    2'd1: wB <= mem_rdata;
                    2'd2: wC <= mem_rdata;
                    2'd3: wD <= mem_rdata;
                endcase
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        base  <= base_addr;
                        row   <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    row <= row + 2'd1;
                    if (row == 2'(NUM_ROWS - 1))
                        state <= WAIT;
                end
                WAIT: state <= LOAD;
                LOAD: begin
                    beat  <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (!stall) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'(NUM_ROWS - 1))
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch.sv
// Bench for weight_fetch: directed test-plan tiles plus randomized
// tiles checked cycle by cycle against a schedule model.
module tb_weight_fetch;
    import weight_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          stall;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [31:0]   wA, wB, wC, wD;
    logic          en_in;
    logic          en_out;

    logic [31:0] mem [256];
    logic [31:0] exp_w [4];
    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    weight_fetch #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .wA        (wA),
        .wB        (wB),
        .wC        (wC),
        .wD        (wD),
        .en_in     (en_in),
        .en_out    (en_out)
    );

    // SRAM with one-cycle read latency; garbage when not strobed.
    always @(posedge clk)
        mem_rdata <= mem_rd_en ? mem[mem_addr] : $urandom;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic stb(input logic [31:0] sb, input int c);
        return (c >= 0 && c < 32) ? sb[c] : 1'b0;
    endfunction

    // One tile: start at relative cycle 0. bs_cyc = extra start while busy,
    // rst_cyc = cycle in which rst is high (-1 = none).
    task automatic run_tile(input int tn, input logic [7:0] b,
                            input logic [31:0] sb, input int bs_cyc,
                            input int rst_cyc);
        int          dc;
        int          beats;
        int          ncyc;
        bit          ab;
        logic [31:0] nw [4];
        string       t;
        beats = 0;
        dc    = 7;
        while (beats < 4) begin
            if (!stb(sb, dc)) beats++;
            dc++;
        end
        ncyc = (rst_cyc >= 0) ? rst_cyc + 5 : dc + 1;
        for (int i = 0; i < 4; i++) nw[i] = mem[8'(b + i)];
        for (int c = 0; c < ncyc; c++) begin
            ab        = (rst_cyc >= 0) && (c > rst_cyc);
            start     = (c == 0) || (c == bs_cyc);
            base_addr = (c == 0) ? b : 8'h40;
            stall     = stb(sb, c);
            rst       = (c == rst_cyc);
            if (c == 6 && !ab) exp_w = nw;
            if (ab) exp_w = '{default: 32'h0};
            @(negedge clk);
            t = $sformatf("t%0d c%0d", tn, c);
            check({t, " busy"}, 32'(busy), 32'(!ab && c >= 1 && c <= dc));
            check({t, " done"}, 32'(done), 32'(!ab && c == dc));
            check({t, " rd_en"}, 32'(mem_rd_en), 32'(!ab && c >= 1 && c <= 4));
            check({t, " en_in"}, 32'(en_in), 32'(!ab && c == 6));
            check({t, " en_out"}, 32'(en_out),
                  32'(!ab && c >= 7 && c < dc && !stall));
            if (!ab && c >= 1 && c <= 4)
                check({t, " addr"}, 32'(mem_addr), 32'(8'(b + c - 1)));
            if (ab)
                check({t, " addr_rst"}, 32'(mem_addr), 32'h0);
            if (c < 2 || c > 5 || ab) begin
                check({t, " wA"}, wA, exp_w[0]);
                check({t, " wB"}, wB, exp_w[1]);
                check({t, " wC"}, wC, exp_w[2]);
                check({t, " wD"}, wD, exp_w[3]);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        int rc;
        int bc;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h10] = 32'h11223344;
        mem[8'h11] = 32'h55667788;
        mem[8'h12] = 32'h99AABBCC;
        mem[8'h13] = 32'hDDEEFF00;
        foreach (exp_w[i]) exp_w[i] = 32'h0;
        rst       = 1'b1;
        start     = 1'b0;
        stall     = 1'b0;
        base_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset rd_en", 32'(mem_rd_en), 32'h0);
        check("reset addr", 32'(mem_addr), 32'h0);
        check("reset en_in", 32'(en_in), 32'h0);
        check("reset en_out", 32'(en_out), 32'h0);
        check("reset wA", wA, 32'h0);
        check("reset wD", wD, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_tile(1, 8'h10, 32'h0, -1, -1);
        run_tile(2, 8'h10, 32'h300, -1, -1);
        run_tile(3, 8'hFE, 32'h0, -1, -1);
        run_tile(4, 8'h10, 32'h0, 3, -1);
        run_tile(5, 8'h10, 32'h0, -1, 8);
        run_tile(6, 8'h20, 32'h0, -1, -1);
        run_tile(7, 8'h30, 32'h0, -1, -1);

        for (int n = 0; n < 24; n++) begin
            rc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 11)) : -1;
            bc = (rc < 0 && $urandom_range(0, 1) == 1)
                 ? int'($urandom_range(1, 11)) : -1;
            run_tile(100 + n, 8'($urandom), $urandom & $urandom, bc, rc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
